// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limit and sequencer states
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: single-digit BCD adder with decimal carry correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);
  logic [4:0] t;
  logic [4:0] tc;
  assign t  = {1'b0, x} + {1'b0, y} + {4'd0, ci};
  assign tc = t + 5'd6;
  assign co = t > {1'b0, BCD_MAX};
  assign s  = co ? tc[3:0] : t[3:0];
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed BCD adder, LSD first, one digit per clock
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] ra, rb;
  logic carry, last, dco;
  bcd_digit_t da, db, ds;
  assign da   = ra[4*idx +: 4];
  assign db   = rb[4*idx +: 4];
  assign last = idx == IW'(DIGITS - 1);
  bcd_digit_add u_digit (.x(da), .y(db), .ci(carry), .s(ds), .co(dco));
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // busy/done are registered views of the state, so they trail it by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
      carry   <= 1'b0;
      ra      <= '0;
      rb      <= '0;
    end else begin
      state <= state_n;
      busy  <= state == RUN;
      done  <= state == DONE;
      if (state == IDLE && start) begin
        ra      <= a;
        rb      <= b;
        carry   <= cin;
        sum     <= '0;
        cout    <= 1'b0;
        invalid <= 1'b0;
        idx     <= '0;
      end
      if (state == RUN) begin
        sum[4*idx +: 4] <= ds;
        carry           <= dco;
        invalid         <= invalid | (da > BCD_MAX) | (db > BCD_MAX);
        idx             <= last ? '0 : idx + 1'b1;
        if (last) cout <= dco;
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: table-driven and scoreboard checks of the serial BCD adder
module tb_bcd_serial_adder;
  localparam int D = 4;
  localparam int W = 4 * D;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, invalid;
  logic [W-1:0] sum;
  typedef struct {
    logic [W-1:0] a, b;
    logic         ci;
    logic [W-1:0] s;
    logic         co, inv;
  } vec_t;
  typedef struct {
    logic [W-1:0] s;
    logic         co, inv;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[8];
  int vecs = 0, errs = 0, dones = 0;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [4:0] t;
    e.inv = 1'b0;
    for (int i = 0; i < D; i++) begin
      t = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
      e.inv |= (x[4*i +: 4] > 4'd9) | (y[4*i +: 4] > 4'd9);
      c = t > 5'd9;
      t = c ? t + 5'd6 : t;
      e.s[4*i +: 4] = t[3:0];
    end
    e.co = c;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  always @(negedge clk) begin
    if (busy && done) begin
      errs++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
    end
    if (done) begin
      dones++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_done: sum=%0h with empty scoreboard", sum);
      end else begin
        mon_e = q.pop_front();
        check("sum", 32'(sum), 32'(mon_e.s));
        check("cout", 32'(cout), 32'(mon_e.co));
        check("invalid", 32'(invalid), 32'(mon_e.inv));
      end
    end
  end

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input exp_t e);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    wait_done(n);
    check("latency", n, D + 2);
    @(negedge clk);
    check("sum_hold", 32'(sum), 32'(e.s));
    check("inv_hold", 32'(invalid), 32'(e.inv));
  endtask

  initial begin
    int n, d0;
    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[4] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
    tbl[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h4321, 16'h0000, 1'b0, 16'h4321, 1'b0, 1'b0};
    tbl[7] = '{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_invalid", 32'(invalid), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      run_add(tbl[i].a, tbl[i].b, tbl[i].ci, '{tbl[i].s, tbl[i].co, tbl[i].inv});
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom);
      run_add(ra, rb, rc, model(ra, rb, rc));
    end
    // second start during RUN must be ignored
    d0 = dones;
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    q.push_back('{16'h0010, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignored_start_latency", n, D);
    repeat (10) @(negedge clk);
    check("single_done", dones - d0, 1);
    // reset mid-RUN discards the partial sum and suppresses done
    d0 = dones;
    @(negedge clk);
    a = 16'h4444; b = 16'h4444; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sum", 32'(sum), 0);
    check("midrst_cout", 32'(cout), 0);
    repeat (10) @(negedge clk);
    check("midrst_no_done", dones - d0, 0);
    run_add(16'h0001, 16'h0002, 1'b0, '{16'h0003, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
